// File: rtl/pipeline_pkg.sv
// Shared pipeline widths, the ID/EX register layout and its bubble value.
package pipeline_pkg;
  localparam int REG_W     = 5;
  localparam int DATA_W    = 32;
  localparam int ALUCTRL_W = 4;
  localparam int SCNT_W    = 16;

  typedef struct packed {
    logic [REG_W-1:0]     rs;
    logic [REG_W-1:0]     rt;
    logic [REG_W-1:0]     rd;
    logic                 reg_write;
    logic                 mem_read;
    logic                 mem_write;
    logic                 mem_to_reg;
    logic                 alu_src;
    logic                 reg_dst;
    logic [ALUCTRL_W-1:0] alu_ctrl;
    logic [DATA_W-1:0]    rd1;
    logic [DATA_W-1:0]    rd2;
    logic [DATA_W-1:0]    imm;
    logic                 valid;
  } idex_t;

  localparam idex_t IDEX_BUBBLE = '0;

  function automatic logic [SCNT_W-1:0] sat_inc(input logic [SCNT_W-1:0] v);
    return (v == {SCNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction
endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard: a valid load in EX whose destination feeds a source of the
// valid instruction in ID. Register $0 never matches.
module load_use_detect
  import pipeline_pkg::*;
(
  input  logic             idex_valid,
  input  logic             idex_mem_read,
  input  logic [REG_W-1:0] idex_rt,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             hazard
);
  logic rs_hit, rt_hit;

  always_comb begin
    rs_hit = (idex_rt == id_rs);
    rt_hit = id_uses_rt & (idex_rt == id_rt);
    hazard = idex_valid & idex_mem_read & (idex_rt != '0) & id_valid & (rs_hit | rt_hit);
  end
endmodule

// File: rtl/idex_stage.sv
// ID/EX pipeline register with load-use stall generation and a saturating
// stall-cycle counter. A bubble is inserted on flush, stall or empty ID.
module idex_stage
  import pipeline_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [REG_W-1:0]     ID_Rs,
  input  logic [REG_W-1:0]     ID_Rt,
  input  logic [REG_W-1:0]     ID_Rd,
  input  logic                 ID_RegWrite,
  input  logic                 ID_MemRead,
  input  logic                 ID_MemWrite,
  input  logic                 ID_MemtoReg,
  input  logic                 ID_ALUSrc,
  input  logic                 ID_RegDst,
  input  logic [ALUCTRL_W-1:0] ID_ALUCtrl,
  input  logic [DATA_W-1:0]    ID_ReadData1,
  input  logic [DATA_W-1:0]    ID_ReadData2,
  input  logic [DATA_W-1:0]    ID_Imm,
  input  logic                 ID_Valid,
  input  logic                 ID_UsesRt,
  input  logic                 Flush,
  output logic [REG_W-1:0]     IDEX_Rs,
  output logic [REG_W-1:0]     IDEX_Rt,
  output logic [REG_W-1:0]     IDEX_Rd,
  output logic                 IDEX_RegWrite,
  output logic                 IDEX_MemRead,
  output logic                 IDEX_MemWrite,
  output logic                 IDEX_MemtoReg,
  output logic                 IDEX_ALUSrc,
  output logic                 IDEX_RegDst,
  output logic [ALUCTRL_W-1:0] IDEX_ALUCtrl,
  output logic [DATA_W-1:0]    IDEX_ReadData1,
  output logic [DATA_W-1:0]    IDEX_ReadData2,
  output logic [DATA_W-1:0]    IDEX_Imm,
  output logic                 IDEX_Valid,
  output logic                 Stall,
  output logic [SCNT_W-1:0]    StallCount
);
  idex_t             idex_d, idex_q;
  logic [SCNT_W-1:0] stall_count_d, stall_count_q;
  logic              hazard;
  logic              stall;

  load_use_detect u_lud (
    .idex_valid    (idex_q.valid),
    .idex_mem_read (idex_q.mem_read),
    .idex_rt       (idex_q.rt),
    .id_valid      (ID_Valid),
    .id_rs         (ID_Rs),
    .id_rt         (ID_Rt),
    .id_uses_rt    (ID_UsesRt),
    .hazard        (hazard)
  );

  // A taken branch kills the ID instruction, so holding it would be pointless.
  assign stall = hazard & ~Flush;

  always_comb begin
    idex_d = IDEX_BUBBLE;
    if (!(Flush || stall || !ID_Valid)) begin
      idex_d.rs         = ID_Rs;
      idex_d.rt         = ID_Rt;
      idex_d.rd         = ID_Rd;
      idex_d.reg_write  = ID_RegWrite;
      idex_d.mem_read   = ID_MemRead;
      idex_d.mem_write  = ID_MemWrite;
      idex_d.mem_to_reg = ID_MemtoReg;
      idex_d.alu_src    = ID_ALUSrc;
      idex_d.reg_dst    = ID_RegDst;
      idex_d.alu_ctrl   = ID_ALUCtrl;
      idex_d.rd1        = ID_ReadData1;
      idex_d.rd2        = ID_ReadData2;
      idex_d.imm        = ID_Imm;
      idex_d.valid      = 1'b1;
    end
    stall_count_d = stall ? sat_inc(stall_count_q) : stall_count_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idex_q        <= IDEX_BUBBLE;
      stall_count_q <= '0;
    end else begin
      idex_q        <= idex_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign IDEX_Rs        = idex_q.rs;
  assign IDEX_Rt        = idex_q.rt;
  assign IDEX_Rd        = idex_q.rd;
  assign IDEX_RegWrite  = idex_q.reg_write;
  assign IDEX_MemRead   = idex_q.mem_read;
  assign IDEX_MemWrite  = idex_q.mem_write;
  assign IDEX_MemtoReg  = idex_q.mem_to_reg;
  assign IDEX_ALUSrc    = idex_q.alu_src;
  assign IDEX_RegDst    = idex_q.reg_dst;
  assign IDEX_ALUCtrl   = idex_q.alu_ctrl;
  assign IDEX_ReadData1 = idex_q.rd1;
  assign IDEX_ReadData2 = idex_q.rd2;
  assign IDEX_Imm       = idex_q.imm;
  assign IDEX_Valid     = idex_q.valid;
  assign Stall          = stall;
  assign StallCount     = stall_count_q;
endmodule
